// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and constants for the PRBS-8 checker.
package prbs_pkg;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0] TAPS = 8'h1D;

    localparam logic [0:15][7:0] SEG_HEX = {
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

endpackage

// File: rtl/prbs_checker_hex7seg.sv
// hex7seg: nibble to active-high a..g code with the dp in bit 0.
module hex7seg
    import prbs_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {SEG_HEX[i_nib][7:1], i_dp};

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS-8 receiver with saturating error count and hex display.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_CNT  = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       seg1,
    output logic [7:0]       seg2
);

    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_h, w_h_nxt;
    logic [2:0]       r_fill, w_fill_nxt;
    logic [GW-1:0]    r_good, w_good_nxt;
    logic [MW-1:0]    r_miss, w_miss_nxt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_locked, r_err_pulse;
    logic             w_pred, w_new, w_hit;

    assign w_pred = ^(r_h & TAPS);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_hit       = 1'b0;
        w_new       = in_bit;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (r_fill != 3'd7) w_fill_nxt = r_fill + 3'd1;
                    else if (|{in_bit, r_h[7:1]}) begin
                        w_state_nxt = VERIFY;
                        w_good_nxt  = '0;
                    end
                end
                VERIFY: begin
                    if (in_bit == w_pred) begin
                        w_good_nxt = r_good + 1'b1;
                        if (r_good == GOOD_LAST) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = 3'd0;
                    end
                end
                LOCKED: begin
                    // Free-run the local generator so a line error is counted once.
                    w_new = w_pred;
                    if (in_bit == w_pred) w_miss_nxt = '0;
                    else begin
                        w_hit      = 1'b1;
                        w_miss_nxt = r_miss + 1'b1;
                        if (r_miss == MISS_LAST) begin
                            w_state_nxt = HUNT;
                            w_fill_nxt  = 3'd0;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
        w_h_nxt = in_valid ? {w_new, r_h[7:1]} : r_h;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_h         <= '0;
            r_fill      <= '0;
            r_good      <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_h         <= w_h_nxt;
            r_fill      <= w_fill_nxt;
            r_good      <= w_good_nxt;
            r_miss      <= w_miss_nxt;
            r_locked    <= w_state_nxt == LOCKED;
            r_err_pulse <= w_hit;
            if (clr_err) r_err_cnt <= '0;
            else if (w_hit && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

    hex7seg u_seg1 (.i_nib(r_err_cnt[7:4]), .i_dp(1'b0),     .o_seg(seg1));
    hex7seg u_seg2 (.i_nib(r_err_cnt[3:0]), .i_dp(r_locked), .o_seg(seg2));

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: random-stimulus bench against a stream-history model of the checker.
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked, err_pulse;
    logic [7:0] err_cnt, seg1, seg2;

    prbs_checker #(.LOCK_GOOD(16), .LOSS_CNT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .seg1(seg1), .seg2(seg2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] seg_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: the last eight trusted stream bits, oldest first; a generator bit
    // equals the XOR of the bits 8, 6, 5 and 4 positions earlier.
    bit s[$];
    int ms, fill, good, miss, m_cnt;
    bit m_locked, m_pulse, hit, pred, nb, nz;

    always @(posedge clk) begin
        if (rst) begin
            s.delete();
            for (int i = 0; i < 8; i++) s.push_back(1'b0);
            ms = 0; fill = 0; good = 0; miss = 0; m_cnt = 0;
            m_locked = 0; m_pulse = 0;
        end else begin
            hit = 0;
            if (in_valid) begin
                pred = s[0] ^ s[2] ^ s[3] ^ s[4];
                nb = (ms == 2) ? pred : in_bit;
                s.push_back(nb);
                void'(s.pop_front());
                nz = 0;
                for (int i = 0; i < 8; i++) nz |= s[i];
                if (ms == 0) begin
                    if (fill < 7) fill++;
                    else if (nz) begin ms = 1; good = 0; end
                end else if (ms == 1) begin
                    if (in_bit == pred) begin
                        good++;
                        if (good == 16) begin ms = 2; miss = 0; end
                    end else begin ms = 0; fill = 0; end
                end else begin
                    if (in_bit == pred) miss = 0;
                    else begin
                        hit = 1;
                        miss++;
                        if (miss == 4) begin ms = 0; fill = 0; end
                    end
                end
            end
            m_pulse = hit;
            if (clr_err) m_cnt = 0;
            else if (hit && m_cnt < 255) m_cnt++;
            m_locked = (ms == 2);
        end
    end

    always @(negedge clk) begin
        check("locked", {7'd0, locked}, {7'd0, m_locked});
        check("err_pulse", {7'd0, err_pulse}, {7'd0, m_pulse});
        check("err_cnt", err_cnt, 8'(m_cnt));
        check("seg1", seg1, seg_tbl[m_cnt / 16]);
        check("seg2", seg2, seg_tbl[m_cnt % 16] | {7'd0, m_locked});
    end

    logic [7:0] g = 8'h01;

    task automatic send(input bit v, input bit inv, input bit clr);
        in_valid = v;
        clr_err = clr;
        if (v) begin
            in_bit = g[0] ^ inv;
            g = {g[4] ^ g[3] ^ g[2] ^ g[0], g[7:1]};
        end else in_bit = 1'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lock_from_reset(input string name);
        for (int i = 0; i < 23; i++) send(1, 0, 0);
        check({name, "_early"}, {7'd0, locked}, 8'd0);
        send(1, 0, 0);
        check(name, {7'd0, locked}, 8'd1);
        check({name, "_model"}, {7'd0, m_locked}, 8'd1);
    endtask

    initial begin
        do_reset();
        @(posedge clk);
        #1;
        check("rst_locked", {7'd0, locked}, 8'd0);
        check("rst_cnt", err_cnt, 8'h00);
        check("rst_seg2", seg2, 8'hFC);
        lock_from_reset("lock1");
        check("lock1_cnt", err_cnt, 8'h00);
        check("lock1_seg1", seg1, 8'hFC);
        check("lock1_seg2", seg2, 8'hFD);
        for (int i = 0; i < 10; i++) send(1, 0, 0);
        send(1, 1, 0);
        check("single_pulse", {7'd0, err_pulse}, 8'd1);
        check("single_cnt", err_cnt, 8'h01);
        check("single_seg2", seg2, 8'h61);
        check("single_model", 8'(m_cnt), 8'h01);
        send(1, 0, 0);
        check("single_pulse_off", {7'd0, err_pulse}, 8'd0);
        for (int i = 0; i < 20; i++) send(1, 0, 0);
        check("single_after", err_cnt, 8'h01);
        check("single_locked", {7'd0, locked}, 8'd1);
        for (int i = 0; i < 3; i++) send(1, 1, 0);
        check("loss_hold", {7'd0, locked}, 8'd1);
        send(1, 1, 0);
        check("loss_cnt", err_cnt, 8'h05);
        check("loss_unlocked", {7'd0, locked}, 8'd0);
        lock_from_reset("relock");
        do_reset();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_bit = 1'b0;
            @(posedge clk);
            #1;
            check("zero_locked", {7'd0, locked}, 8'd0);
            check("zero_cnt", err_cnt, 8'h00);
        end
        in_valid = 1'b0;
        do_reset();
        for (int n = 0; n < 24; ) begin
            if ($urandom_range(2) == 0) send(0, 0, 0);
            else begin
                n++;
                if (n == 24) check("gap_early", {7'd0, locked}, 8'd0);
                send(1, 0, 0);
            end
        end
        check("gap_lock", {7'd0, locked}, 8'd1);
        for (int i = 0; i < 300; i++) begin
            send(1, 1, 0);
            for (int k = 0; k < 1 + int'($urandom_range(1)); k++) send(1, 0, 0);
        end
        check("sat_cnt", err_cnt, 8'hFF);
        check("sat_model", 8'(m_cnt), 8'hFF);
        check("sat_locked", {7'd0, locked}, 8'd1);
        send(1, 1, 1);
        check("clr_pulse", {7'd0, err_pulse}, 8'd1);
        check("clr_cnt", err_cnt, 8'h00);
        for (int i = 0; i < 3; i++) begin
            send(1, 1, 0);
            send(1, 0, 0);
        end
        check("pre_rst_cnt", err_cnt, 8'h03);
        do_reset();
        check("midrst_locked", {7'd0, locked}, 8'd0);
        check("midrst_cnt", err_cnt, 8'h00);
        check("midrst_seg2", seg2, 8'hFC);
        lock_from_reset("lock3");
        for (int i = 0; i < 2000; i++)
            send($urandom_range(3) != 0, $urandom_range(11) == 0, $urandom_range(49) == 0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
